// File: rtl/rdm_perf_pkg.sv
// Shared helpers for the RDM performance monitor: keep-byte popcount and
// width-limited saturating addition.
package rdm_perf_pkg;

  localparam int unsigned MaxWidth = 64;

  // Callers zero-extend narrower vectors to MaxWidth.
  function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxWidth; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

  // Sum of a and b, clamped to the all-ones value of a width-bit result.
  function automatic logic [MaxWidth-1:0] sat_add(input logic [MaxWidth-1:0] a,
                                                  input logic [MaxWidth-1:0] b,
                                                  input int unsigned width);
    logic [MaxWidth:0] sum;
    logic [MaxWidth:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{MaxWidth{1'b0}}, 1'b1} << width) - {{MaxWidth{1'b0}}, 1'b1};
    if (sum > lim) begin
      sum = lim;
    end
    return sum[MaxWidth-1:0];
  endfunction

endpackage

// File: rtl/axis_rdm_perf_monitor_if.sv
// AXI-Stream snoop bundle: the master side drives the stream, the monitor only observes it.
interface axis_rdm_perf_monitor_if #(
  parameter int unsigned KEEP_WIDTH = 32
) ();

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [KEEP_WIDTH-1:0] tkeep;

  modport master (output tvalid, output tready, output tlast, output tkeep);
  modport slave  (input  tvalid, input  tready, input  tlast, input  tkeep);

endinterface

// File: rtl/axis_rdm_perf_ts_fifo.sv
// First-word-fall-through timestamp FIFO with occupancy count; a pop frees the slot
// for a same-cycle push even when full.
module axis_rdm_perf_ts_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/axis_rdm_perf_monitor.sv
// Passive request/response monitor: counts packets and bytes, matches in-order responses
// to requests and tracks latency statistics plus sticky error flags.
module axis_rdm_perf_monitor
  import rdm_perf_pkg::*;
#(
  parameter int unsigned KEEP_WIDTH     = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TS_WIDTH       = 32,
  parameter int unsigned CNT_WIDTH      = 48,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      stat_clear,
  axis_rdm_perf_monitor_if.slave    req,
  axis_rdm_perf_monitor_if.slave    rsp,
  output logic [CNT_WIDTH-1:0]      nr_req,
  output logic [CNT_WIDTH-1:0]      nr_rsp,
  output logic [CNT_WIDTH-1:0]      req_bytes,
  output logic [CNT_WIDTH-1:0]      rsp_bytes,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      idle,
  output logic                      lat_valid,
  output logic [TS_WIDTH-1:0]       lat_last,
  output logic [TS_WIDTH-1:0]       lat_min,
  output logic [TS_WIDTH-1:0]       lat_max,
  output logic [CNT_WIDTH-1:0]      lat_sum,
  output logic                      err_timeout,
  output logic                      err_overflow,
  output logic                      err_unexpected
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [KEEP_WIDTH-1:0] req_keep, rsp_keep;
  logic                  req_hs, req_last, rsp_hs, rsp_last, rsp_pop;
  logic                  overflow_evt, unexpected_evt, age_hit;
  logic                  fifo_full, fifo_empty;
  logic [TS_WIDTH-1:0]   fifo_head, push_ts, age;
  logic [CW-1:0]         fifo_count;

  logic [TS_WIDTH-1:0]   ts_q, start_q, start_d;
  logic                  in_pkt_q, in_pkt_d;

  logic [CNT_WIDTH-1:0]  nr_req_q, nr_req_d, nr_rsp_q, nr_rsp_d;
  logic [CNT_WIDTH-1:0]  req_bytes_q, req_bytes_d, rsp_bytes_q, rsp_bytes_d;
  logic                  lat_valid_q, lat_valid_d;
  logic [TS_WIDTH-1:0]   lat_last_q, lat_last_d, lat_min_q, lat_min_d, lat_max_q, lat_max_d;
  logic [CNT_WIDTH-1:0]  lat_sum_q, lat_sum_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_unexpected_q, err_unexpected_d;

  assign req_keep = req.tkeep;
  assign rsp_keep = rsp.tkeep;
  assign req_hs   = req.tvalid && req.tready;
  assign rsp_hs   = rsp.tvalid && rsp.tready;
  assign req_last = req_hs && req.tlast;
  assign rsp_last = rsp_hs && rsp.tlast;
  assign rsp_pop  = rsp_last && !fifo_empty;

  // A single-beat packet starts in the cycle it ends.
  assign push_ts        = in_pkt_q ? start_q : ts_q;
  assign overflow_evt   = req_last && fifo_full && !rsp_pop;
  assign unexpected_evt = rsp_last && fifo_empty;
  assign age            = ts_q - fifo_head;
  assign age_hit        = !fifo_empty && (age >= TS_WIDTH'(TIMEOUT_CYCLES));

  axis_rdm_perf_ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_WIDTH)
  ) u_ts_fifo (
    .clk_i   (clk),
    .rst_i   (sys_rst),
    .push_i  (req_last),
    .data_i  (push_ts),
    .pop_i   (rsp_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    start_d  = start_q;
    in_pkt_d = in_pkt_q;
    if (req_hs) begin
      if (!in_pkt_q) start_d = ts_q;
      in_pkt_d = !req.tlast;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      ts_q     <= '0;
      start_q  <= '0;
      in_pkt_q <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_WIDTH'(1);
      start_q  <= start_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  always_comb begin
    nr_req_d         = nr_req_q;
    nr_rsp_d         = nr_rsp_q;
    req_bytes_d      = req_bytes_q;
    rsp_bytes_d      = rsp_bytes_q;
    lat_valid_d      = 1'b0;
    lat_last_d       = lat_last_q;
    lat_min_d        = lat_min_q;
    lat_max_d        = lat_max_q;
    lat_sum_d        = lat_sum_q;
    err_timeout_d    = err_timeout_q;
    err_overflow_d   = err_overflow_q;
    err_unexpected_d = err_unexpected_q;

    if (req_hs)   req_bytes_d = req_bytes_q + CNT_WIDTH'(popcount(MaxWidth'(req_keep)));
    if (rsp_hs)   rsp_bytes_d = rsp_bytes_q + CNT_WIDTH'(popcount(MaxWidth'(rsp_keep)));
    if (req_last) nr_req_d = nr_req_q + CNT_WIDTH'(1);
    if (rsp_last) nr_rsp_d = nr_rsp_q + CNT_WIDTH'(1);

    if (rsp_pop) begin
      lat_valid_d = 1'b1;
      lat_last_d  = age;
      if (age < lat_min_q) lat_min_d = age;
      if (age > lat_max_q) lat_max_d = age;
      lat_sum_d = CNT_WIDTH'(sat_add(MaxWidth'(lat_sum_q), MaxWidth'(age), CNT_WIDTH));
    end

    if (overflow_evt)   err_overflow_d   = 1'b1;
    if (unexpected_evt) err_unexpected_d = 1'b1;
    if (age_hit)        err_timeout_d    = 1'b1;

    // Clear overrides anything that happened this cycle, including a due lat_valid.
    if (stat_clear) begin
      nr_req_d         = '0;
      nr_rsp_d         = '0;
      req_bytes_d      = '0;
      rsp_bytes_d      = '0;
      lat_valid_d      = 1'b0;
      lat_last_d       = '0;
      lat_min_d        = '1;
      lat_max_d        = '0;
      lat_sum_d        = '0;
      err_timeout_d    = 1'b0;
      err_overflow_d   = 1'b0;
      err_unexpected_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      nr_req_q         <= '0;
      nr_rsp_q         <= '0;
      req_bytes_q      <= '0;
      rsp_bytes_q      <= '0;
      lat_valid_q      <= 1'b0;
      lat_last_q       <= '0;
      lat_min_q        <= '1;
      lat_max_q        <= '0;
      lat_sum_q        <= '0;
      err_timeout_q    <= 1'b0;
      err_overflow_q   <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      nr_req_q         <= nr_req_d;
      nr_rsp_q         <= nr_rsp_d;
      req_bytes_q      <= req_bytes_d;
      rsp_bytes_q      <= rsp_bytes_d;
      lat_valid_q      <= lat_valid_d;
      lat_last_q       <= lat_last_d;
      lat_min_q        <= lat_min_d;
      lat_max_q        <= lat_max_d;
      lat_sum_q        <= lat_sum_d;
      err_timeout_q    <= err_timeout_d;
      err_overflow_q   <= err_overflow_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  assign nr_req         = nr_req_q;
  assign nr_rsp         = nr_rsp_q;
  assign req_bytes      = req_bytes_q;
  assign rsp_bytes      = rsp_bytes_q;
  assign outstanding    = fifo_count;
  assign idle           = fifo_empty;
  assign lat_valid      = lat_valid_q;
  assign lat_last       = lat_last_q;
  assign lat_min        = lat_min_q;
  assign lat_max        = lat_max_q;
  assign lat_sum        = lat_sum_q;
  assign err_timeout    = err_timeout_q;
  assign err_overflow   = err_overflow_q;
  assign err_unexpected = err_unexpected_q;

endmodule

// File: tb/tb_axis_rdm_perf_monitor.sv
// Randomised and directed bench for axis_rdm_perf_monitor with a queue-based reference model
// and a latency scoreboard fed by the model and drained on lat_valid.
module tb_axis_rdm_perf_monitor;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 100;

  logic clk, sys_rst, stat_clear;
  logic [11:0] nr_req, nr_rsp, req_bytes, rsp_bytes, lat_sum;
  logic [2:0]  outstanding;
  logic        idle, lat_valid, err_timeout, err_overflow, err_unexpected;
  logic [7:0]  lat_last, lat_min, lat_max;

  axis_rdm_perf_monitor_if #(.KEEP_WIDTH(32)) req_if ();
  axis_rdm_perf_monitor_if #(.KEEP_WIDTH(32)) rsp_if ();

  axis_rdm_perf_monitor #(
    .KEEP_WIDTH     (32),
    .DEPTH          (Depth),
    .TS_WIDTH       (8),
    .CNT_WIDTH      (12),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk            (clk),
    .sys_rst        (sys_rst),
    .stat_clear     (stat_clear),
    .req            (req_if),
    .rsp            (rsp_if),
    .nr_req         (nr_req),
    .nr_rsp         (nr_rsp),
    .req_bytes      (req_bytes),
    .rsp_bytes      (rsp_bytes),
    .outstanding    (outstanding),
    .idle           (idle),
    .lat_valid      (lat_valid),
    .lat_last       (lat_last),
    .lat_min        (lat_min),
    .lat_max        (lat_max),
    .lat_sum        (lat_sum),
    .err_timeout    (err_timeout),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  lat;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [11:0] sum;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_ts, m_start, m_last, m_min, m_max;
  logic [11:0] m_nr_req, m_nr_rsp, m_req_bytes, m_rsp_bytes, m_sum;
  bit          m_in_pkt, m_to, m_ovf, m_unexp;

  task automatic model_clear_stats();
    m_nr_req = 0; m_nr_rsp = 0; m_req_bytes = 0; m_rsp_bytes = 0;
    m_last = 0; m_min = 8'hff; m_max = 0; m_sum = 0;
    m_to = 0; m_ovf = 0; m_unexp = 0;
  endtask

  task automatic model_reset();
    model_clear_stats();
    m_fifo.delete();
    exp_q.delete();
    m_ts = 0; m_start = 0; m_in_pkt = 0;
  endtask

  task automatic model_step();
    bit rh, rl, sh, sl, clr;
    logic [7:0] lat, age;
    int s;
    rh  = req_if.tvalid && req_if.tready;
    rl  = rh && req_if.tlast;
    sh  = rsp_if.tvalid && rsp_if.tready;
    sl  = sh && rsp_if.tlast;
    clr = stat_clear;
    if (m_fifo.size() != 0) begin
      age = m_ts - m_fifo[0];
      if (age >= 8'(Timeout)) m_to = 1;
    end
    if (rh) m_req_bytes += 12'($countones(req_if.tkeep));
    if (sh) m_rsp_bytes += 12'($countones(rsp_if.tkeep));
    if (rl) m_nr_req++;
    if (sl) begin
      m_nr_rsp++;
      if (m_fifo.size() == 0) m_unexp = 1;
      else begin
        lat = m_ts - m_fifo.pop_front();
        m_last = lat;
        if (lat < m_min) m_min = lat;
        if (lat > m_max) m_max = lat;
        s = int'(m_sum) + int'(lat);
        m_sum = (s > 4095) ? 12'hfff : 12'(s);
        if (!clr) exp_q.push_back('{lat: m_last, mn: m_min, mx: m_max, sum: m_sum});
      end
    end
    if (rh && !m_in_pkt) m_start = m_ts;
    if (rl) begin
      if (m_fifo.size() < Depth) m_fifo.push_back(m_start);
      else m_ovf = 1;
    end
    if (rh) m_in_pkt = !req_if.tlast;
    if (clr) model_clear_stats();
    m_ts++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (sys_rst) model_reset();
      else model_step();
    end
  end

  // ---------------- latency scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (lat_valid) begin
        if (exp_q.size() == 0) chk("lat_valid_spurious", 64'(lat_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_lat_last", 64'(lat_last), 64'(e.lat));
          chk("sb_lat_min", 64'(lat_min), 64'(e.mn));
          chk("sb_lat_max", 64'(lat_max), 64'(e.mx));
          chk("sb_lat_sum", 64'(lat_sum), 64'(e.sum));
        end
      end else if (exp_q.size() != 0) begin
        chk("sb_lat_valid_missing", 64'(lat_valid), 64'd1);
        exp_q.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  // Each call sets the inputs for the next rising edge and returns at the following negedge.
  task automatic drive(input bit rv, input bit rr, input bit rl, input logic [31:0] rk,
                       input bit sv, input bit sr, input bit sl, input logic [31:0] sk,
                       input bit clr);
    req_if.tvalid = rv; req_if.tready = rr; req_if.tlast = rl; req_if.tkeep = rk;
    rsp_if.tvalid = sv; rsp_if.tready = sr; rsp_if.tlast = sl; rsp_if.tkeep = sk;
    stat_clear = clr;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    drive(0, 1, 0, '0, 0, 1, 0, '0, 0);
  endtask

  task automatic req_beat(input bit last);
    drive(1, 1, last, 32'hffff_ffff, 0, 1, 0, '0, 0);
  endtask

  task automatic rsp_beat();
    drive(0, 1, 0, '0, 1, 1, 1, 32'h0000_000f, 0);
  endtask

  task automatic wait_ts(input logic [7:0] t);
    for (int i = 0; i < 600 && m_ts != t; i++) idle_cyc();
    if (m_ts != t) chk("wait_ts_bound", 64'(m_ts), 64'(t));
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    drive(0, 1, 0, '0, 0, 1, 0, '0, 0);
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_nr_req"}, 64'(nr_req), 64'(m_nr_req));
    chk({tag, "_nr_rsp"}, 64'(nr_rsp), 64'(m_nr_rsp));
    chk({tag, "_req_bytes"}, 64'(req_bytes), 64'(m_req_bytes));
    chk({tag, "_rsp_bytes"}, 64'(rsp_bytes), 64'(m_rsp_bytes));
    chk({tag, "_outstanding"}, 64'(outstanding), 64'(m_fifo.size()));
    chk({tag, "_idle"}, 64'(idle), 64'(m_fifo.size() == 0));
    chk({tag, "_lat_last"}, 64'(lat_last), 64'(m_last));
    chk({tag, "_lat_min"}, 64'(lat_min), 64'(m_min));
    chk({tag, "_lat_max"}, 64'(lat_max), 64'(m_max));
    chk({tag, "_lat_sum"}, 64'(lat_sum), 64'(m_sum));
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(m_to));
    chk({tag, "_err_overflow"}, 64'(err_overflow), 64'(m_ovf));
    chk({tag, "_err_unexpected"}, 64'(err_unexpected), 64'(m_unexp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev;
    model_reset();
    sys_rst = 1'b1;
    drive(0, 1, 0, '0, 0, 1, 0, '0, 0);
    @(negedge clk);
    sys_rst = 1'b0;

    // Reset values
    chk("rst_lat_min", 64'(lat_min), 64'hff);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_lat_valid", 64'(lat_valid), 64'd0);
    chk("rst_nr_req", 64'(nr_req), 64'd0);
    check_all("rst");

    // 1: 4-beat request from ts=10, response at ts=50
    wait_ts(10);
    for (int i = 0; i < 4; i++) req_beat(i == 3);
    wait_ts(50);
    rsp_beat();
    chk("t1_lat_valid", 64'(lat_valid), 64'd1);
    chk("t1_lat_last", 64'(lat_last), 64'd40);
    chk("t1_lat_min", 64'(lat_min), 64'd40);
    chk("t1_lat_max", 64'(lat_max), 64'd40);
    chk("t1_nr_req", 64'(nr_req), 64'd1);
    chk("t1_req_bytes", 64'(req_bytes), 64'd128);
    idle_cyc();
    chk("t1_lat_valid_pulse", 64'(lat_valid), 64'd0);
    check_all("t1");

    // 2: DEPTH+1 back-to-back requests, then DEPTH responses
    do_reset();
    for (int i = 0; i < Depth + 1; i++) req_beat(1);
    chk("t2_outstanding", 64'(outstanding), 64'(Depth));
    chk("t2_err_overflow", 64'(err_overflow), 64'd1);
    chk("t2_nr_req", 64'(nr_req), 64'(Depth + 1));
    prev = 0;
    for (int i = 0; i < Depth; i++) begin
      rsp_beat();
      chk("t2_lat_valid", 64'(lat_valid), 64'd1);
      chk("t2_monotone", 64'(lat_last >= prev), 64'd1);
      prev = lat_last;
      repeat ($urandom_range(0, 3)) idle_cyc();
    end
    chk("t2_idle", 64'(idle), 64'd1);
    check_all("t2");

    // 3: response on empty FIFO, then same-cycle push and pop on empty FIFO
    do_reset();
    rsp_beat();
    chk("t3_err_unexpected", 64'(err_unexpected), 64'd1);
    chk("t3_nr_rsp", 64'(nr_rsp), 64'd1);
    chk("t3_lat_valid", 64'(lat_valid), 64'd0);
    chk("t3_lat_min", 64'(lat_min), 64'hff);
    do_reset();
    drive(1, 1, 1, 32'hffff_ffff, 1, 1, 1, 32'h1, 0);
    chk("t3b_err_unexpected", 64'(err_unexpected), 64'd1);
    chk("t3b_outstanding", 64'(outstanding), 64'd1);
    chk("t3b_lat_valid", 64'(lat_valid), 64'd0);
    check_all("t3");

    // 4: timeout after TIMEOUT_CYCLES of head-of-line age, then stat_clear
    do_reset();
    wait_ts(5);
    req_beat(1);
    wait_ts(8'(5 + Timeout));
    chk("t4_timeout_early", 64'(err_timeout), 64'd0);
    idle_cyc();
    chk("t4_timeout_set", 64'(err_timeout), 64'd1);
    drive(0, 1, 0, '0, 0, 1, 0, '0, 1);
    chk("t4_timeout_cleared", 64'(err_timeout), 64'd0);
    chk("t4_outstanding", 64'(outstanding), 64'd1);
    check_all("t4");

    // 5: wrapped timestamp latency, then drive lat_sum into saturation
    do_reset();
    wait_ts(250);
    req_beat(1);
    wait_ts(4);
    rsp_beat();
    chk("t5_lat_wrap", 64'(lat_last), 64'd10);
    for (int i = 0; i < 22; i++) begin
      req_beat(1);
      repeat (200) idle_cyc();
      rsp_beat();
    end
    chk("t5_lat_sum_sat", 64'(lat_sum), 64'hfff);
    check_all("t5");
    chk("t5_sat_w1", rdm_perf_pkg::sat_add(64'd1, 64'd1, 1), 64'd1);
    chk("t5_sat_w1_zero", rdm_perf_pkg::sat_add(64'd0, 64'd0, 1), 64'd0);
    chk("t5_sat_w8_nosat", rdm_perf_pkg::sat_add(64'd5, 64'd7, 8), 64'd12);
    chk("t5_sat_w8_sat", rdm_perf_pkg::sat_add(64'd200, 64'd100, 8), 64'd255);
    chk("t5_popcount", 64'(rdm_perf_pkg::popcount(64'h0000_f0f0)), 64'd8);

    // 6: reset mid-packet, then a fresh 2-beat request
    do_reset();
    wait_ts(3);
    req_beat(0);
    req_beat(0);
    do_reset();
    wait_ts(7);
    req_beat(0);
    req_beat(1);
    wait_ts(20);
    rsp_beat();
    chk("t6_lat_last", 64'(lat_last), 64'd13);
    chk("t6_nr_req", 64'(nr_req), 64'd1);
    check_all("t6");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      bit sv;
      sv = (m_fifo.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom, sv, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 59) == 0);
      if (i % 100 == 99) check_all("rnd");
    end
    idle_cyc();
    check_all("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
